// File: rtl/mac_pkg.sv
// Shared types and constants for the byte-sum MAC read sequencer.
package mac_pkg;

  // Run sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_SETTLE = 3'd4
  } seq_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Bytes carried by one data beat
  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Number of low address bits cleared so a full burst never crosses its own size boundary
  function automatic int align_bits(input int data_w, input int burst_len);
    return $clog2(burst_len * (data_w / 8));
  endfunction

  // AXI arsize encoding for a full-width beat
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/mac_rd_sequencer_if.sv
// AXI read-address channel plus R-channel monitor taps seen by the sequencer.
interface mac_rd_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic              r_valid;
  logic              r_ready;
  logic              r_last;
  logic [1:0]        r_resp;

  // Sequencer side: drives AR, only observes R
  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready, r_valid, r_ready, r_last, r_resp
  );

  // Interconnect / memory side
  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready, r_valid, r_ready, r_last, r_resp
  );

endinterface

// File: rtl/mac_rd_outst_cnt.sv
// Outstanding-burst counter: up on AR handshake, down on final R beat, full at MAX_OUTST.
module mac_rd_outst_cnt #(
  parameter int MAX_OUTST = 4,
  parameter int CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_full
);

  logic [CW-1:0] r_count;

  // Simultaneous inc and dec cancel; a stray rlast with nothing outstanding is ignored
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + CW'(1);
    end else if (!i_inc && i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count >= CW'(MAX_OUTST));

endmodule

// File: rtl/mac_rd_sequencer.sv
// Sequences one DDR read run into the byte-sum MAC: clears the MAC, issues INCR bursts
// over the configured region with bounded outstanding bursts, drains, then captures
// the sum, elapsed cycles and error status.
module mac_rd_sequencer
  import mac_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4,
  parameter int PIPE_LAT  = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [31:0]        cfg_nbeats,
  mac_rd_sequencer_if.master axi,
  output logic               mac_start,
  input  logic [31:0]        mac_sum,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        result,
  output logic [31:0]        cycles,
  output logic [31:0]        beats_rx
);

  localparam int BEAT_B = beat_bytes(DATA_W);
  localparam int ALIGN  = align_bits(DATA_W, BURST_LEN);
  localparam int OW     = $clog2(MAX_OUTST + 1);
  localparam int SW     = $clog2(PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN) - ADDR_W'(1));

  seq_state_e        r_state;
  seq_state_e        w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rem;
  logic              r_ar_hold;
  logic              r_abort;
  logic [SW-1:0]     r_settle;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_result;
  logic [31:0]       r_cycles;
  logic [31:0]       r_beats;

  logic [OW-1:0]     w_outst;
  logic              w_full;
  logic              w_arvalid;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_r_end;
  logic              w_accept;
  logic              w_abort_any;
  logic              w_settle_end;
  logic              w_resp_bad;
  logic [31:0]       w_burst_beats;
  logic [7:0]        w_len_m1;
  logic [ADDR_W-1:0] w_burst_bytes;

  assign w_accept      = (r_state == ST_IDLE) && cfg_start;
  assign w_abort_any   = r_abort || cfg_abort;
  assign w_ar_hs       = w_arvalid && axi.m_axi_arready;
  assign w_r_hs        = axi.r_valid && axi.r_ready;
  assign w_r_end       = w_r_hs && axi.r_last;
  assign w_resp_bad    = (axi.r_resp == AXI_RESP_SLVERR) || (axi.r_resp == AXI_RESP_DECERR);
  assign w_settle_end  = (r_state == ST_SETTLE) && (r_settle == SW'(PIPE_LAT - 1));
  assign w_burst_beats = (r_rem < 32'(BURST_LEN)) ? r_rem : 32'(BURST_LEN);
  assign w_len_m1      = 8'(w_burst_beats - 32'd1);
  assign w_burst_bytes = ADDR_W'(w_burst_beats * 32'(BEAT_B));

  mac_rd_outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .CW        (OW)
  ) u_outst (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (w_ar_hs),
    .i_dec   (w_r_end),
    .o_count (w_outst),
    .o_full  (w_full)
  );

  // State register; reset drops any run immediately
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: an AR already presented always completes before leaving ISSUE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_next = ST_CLR;
      end
      ST_CLR: begin
        w_next = (r_rem == 32'd0) ? ST_SETTLE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_ar_hs) begin
          if ((r_rem == w_burst_beats) || w_abort_any) w_next = ST_DRAIN;
        end else if (!w_arvalid && w_abort_any) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_outst == '0) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_settle_end) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Moore outputs: clear pulse, busy, and AR valid (held once presented)
  always_comb begin
    mac_start = 1'b0;
    busy      = 1'b1;
    w_arvalid = 1'b0;
    case (r_state)
      ST_IDLE:  busy = 1'b0;
      ST_CLR:   mac_start = 1'b1;
      ST_ISSUE: w_arvalid = r_ar_hold || (!w_full && (r_rem != 32'd0) && !r_abort);
      default:  ;
    endcase
  end

  // Burst address and remaining beats: loaded at accept, advanced per AR handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_addr <= cfg_addr & ALIGN_MASK;
      r_rem  <= cfg_nbeats;
    end else if (w_ar_hs) begin
      r_addr <= r_addr + w_burst_bytes;
      r_rem  <= r_rem - w_burst_beats;
    end
  end

  // Remember an AR that was presented but not yet accepted so abort cannot withdraw it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ar_hold <= 1'b0;
    end else if (w_ar_hs || (r_state != ST_ISSUE)) begin
      r_ar_hold <= 1'b0;
    end else if (w_arvalid) begin
      r_ar_hold <= 1'b1;
    end
  end

  // Abort request latched for the rest of the run; ignored while idle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_abort <= 1'b0;
    end else if (w_accept) begin
      r_abort <= 1'b0;
    end else if (cfg_abort && busy) begin
      r_abort <= 1'b1;
    end
  end

  // Settle timer gives the MAC pipeline time to fold in the final beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_settle <= '0;
    end else if (r_state != ST_SETTLE) begin
      r_settle <= '0;
    end else begin
      r_settle <= r_settle + SW'(1);
    end
  end

  // Sticky status: done at capture, err on bad response or abort; both cleared on accept
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_settle_end) r_done <= 1'b1;
      if (busy && (cfg_abort || (w_r_hs && w_resp_bad))) r_err <= 1'b1;
    end
  end

  // Run statistics: saturating busy-cycle count, R beat count, captured sum
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cycles <= '0;
      r_beats  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
      r_beats  <= '0;
    end else begin
      if (busy && (r_cycles != 32'hFFFF_FFFF)) r_cycles <= r_cycles + 32'd1;
      if (busy && w_r_hs) r_beats <= r_beats + 32'd1;
      if (w_settle_end) r_result <= mac_sum;
    end
  end

  assign axi.m_axi_araddr  = r_addr;
  assign axi.m_axi_arlen   = w_len_m1;
  assign axi.m_axi_arsize  = axi_size(DATA_W);
  assign axi.m_axi_arburst = AXI_BURST_INCR;
  assign axi.m_axi_arvalid = w_arvalid;

  assign done     = r_done;
  assign err      = r_err;
  assign result   = r_result;
  assign cycles   = r_cycles;
  assign beats_rx = r_beats;

endmodule

// File: tb/tb_mac_rd_sequencer.sv
// Directed bench for mac_rd_sequencer with an AXI read slave and byte-sum MAC stand-in.
module tb_mac_rd_sequencer;
  import mac_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 16;
  localparam int MAX_OUTST = 4;
  localparam int PIPE_LAT  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_nbeats = '0;
  logic        mac_start;
  logic [31:0] mac_sum;
  logic        busy, done, err;
  logic [31:0] result, cycles, beats_rx;

  mac_rd_sequencer_if #(.ADDR_W(ADDR_W)) axi();

  mac_rd_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .MAX_OUTST(MAX_OUTST), .PIPE_LAT(PIPE_LAT)
  ) u_dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_addr(cfg_addr), .cfg_nbeats(cfg_nbeats), .axi(axi),
    .mac_start(mac_start), .mac_sum(mac_sum), .busy(busy), .done(done), .err(err),
    .result(result), .cycles(cycles), .beats_rx(beats_rx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;
  burst_t      q[$];
  int unsigned ar_cnt = 0, ms_cnt = 0, total_beats = 0;
  logic [31:0] ar_addr [256];
  logic [7:0]  ar_len  [256];
  int          r_beat = 0;
  logic [31:0] acc = '0, pipe0 = '0;
  logic        r_en = 1'b1;
  int unsigned err_beat = 32'hFFFF_FFFF;
  int unsigned beat_base = 0, ar0 = 0, ms0 = 0;
  int          n_chk = 0, n_err = 0;

  // Byte sum of one 8-byte beat whose byte i holds (address+i) mod 256
  function automatic logic [31:0] beatsum(input logic [31:0] a);
    logic [31:0] s = '0;
    for (int i = 0; i < 8; i++) s += (a + 32'(i)) & 32'hFF;
    return s;
  endfunction

  function automatic logic [31:0] exp_sum(input logic [31:0] base, input int nb);
    logic [31:0] s = '0;
    for (int k = 0; k < nb; k++) s += beatsum(base + 32'(k) * 32'd8);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave + MAC model: observe handshakes at the active edge
  initial forever begin
    @(posedge clk);
    if (axi.m_axi_arvalid && axi.m_axi_arready) begin
      ar_addr[ar_cnt % 256] = axi.m_axi_araddr;
      ar_len[ar_cnt % 256]  = axi.m_axi_arlen;
      q.push_back('{axi.m_axi_araddr, axi.m_axi_arlen});
      ar_cnt++;
    end
    pipe0 = acc;
    if (mac_start) begin
      acc = '0;
      ms_cnt++;
    end else if (axi.r_valid && axi.r_ready && (q.size() != 0)) begin
      acc = acc + beatsum(q[0].addr + 32'(r_beat) * 32'd8);
      total_beats++;
      if (axi.r_last) begin
        void'(q.pop_front());
        r_beat = 0;
      end else begin
        r_beat++;
      end
    end
  end

  // Drive R monitor taps and MAC sum away from the active edge
  initial forever begin
    @(negedge clk);
    axi.r_valid = r_en && (q.size() != 0);
    axi.r_last  = 1'b0;
    if (q.size() != 0) axi.r_last = (r_beat == int'(q[0].len));
    axi.r_resp  = (axi.r_valid && ((total_beats - beat_base) == err_beat)) ? AXI_RESP_SLVERR
                                                                           : AXI_RESP_OKAY;
    mac_sum     = pipe0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end

  task automatic snap();
    ar0 = ar_cnt; ms0 = ms_cnt; beat_base = total_beats;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] n);
    cfg_addr = a; cfg_nbeats = n; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_abort();
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  initial begin
    int n;
    axi.m_axi_arready = 1'b1;
    axi.r_ready       = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_result", result, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_beats", beats_rx, 0);
    chk("rst_arvalid", 32'(axi.m_axi_arvalid), 0);
    chk("rst_arsize", 32'(axi.m_axi_arsize), 3);
    chk("rst_arburst", 32'(axi.m_axi_arburst), 1);
    rstn = 1'b1;
    @(negedge clk);

    // 64 beats in 4 full bursts; a second start mid-run must be ignored
    snap();
    pulse_start(32'h2000, 64);
    repeat (10) @(negedge clk);
    pulse_start(32'h9000, 8);
    wait_done("r64", n);
    chk("r64_ars", ar_cnt - ar0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r64_len%0d", i), 32'(ar_len[(ar0 + 32'(i)) % 256]), 15);
      chk($sformatf("r64_addr%0d", i), ar_addr[(ar0 + 32'(i)) % 256], 32'h2000 + 32'(i) * 128);
    end
    chk("r64_beats", beats_rx, 64);
    chk("r64_err", 32'(err), 0);
    chk("r64_result", result, exp_sum(32'h2000, 64));
    chk("r64_busy", 32'(busy), 0);
    chk("r64_macstart", ms_cnt - ms0, 1);

    // Abort while idle changes nothing
    pulse_abort();
    @(negedge clk);
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_err", 32'(err), 0);
    chk("idle_abort_done", 32'(done), 1);

    // 20 beats: one full burst then a 4-beat tail
    snap();
    pulse_start(32'h3000, 20);
    wait_done("r20", n);
    chk("r20_ars", ar_cnt - ar0, 2);
    chk("r20_len0", 32'(ar_len[ar0 % 256]), 15);
    chk("r20_len1", 32'(ar_len[(ar0 + 1) % 256]), 3);
    chk("r20_addr1", ar_addr[(ar0 + 1) % 256], 32'h3080);
    chk("r20_beats", beats_rx, 20);
    chk("r20_result", result, exp_sum(32'h3000, 20));

    // Zero-length run: no AR, one clear pulse, result is the cleared sum
    snap();
    pulse_start(32'h3000, 0);
    wait_done("r0", n);
    chk("r0_latency_ok", 32'((n + 1) <= (PIPE_LAT + 3)), 1);
    chk("r0_ars", ar_cnt - ar0, 0);
    chk("r0_macstart", ms_cnt - ms0, 1);
    chk("r0_result", result, 0);
    chk("r0_cycles", cycles, 3);
    chk("r0_beats", beats_rx, 0);

    // R stalled: issue stops at MAX_OUTST until the first rlast
    snap();
    r_en = 1'b0;
    pulse_start(32'h4000, 128);
    repeat (30) @(negedge clk);
    chk("stall_ars", ar_cnt - ar0, 4);
    chk("stall_arvalid", 32'(axi.m_axi_arvalid), 0);
    chk("stall_busy", 32'(busy), 1);
    r_en = 1'b1;
    n = 0;
    while ((total_beats - beat_base) < 15 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_pre_rlast_ars", ar_cnt - ar0, 4);
    wait_done("stall", n);
    chk("stall_ars_end", ar_cnt - ar0, 8);
    chk("stall_beats", beats_rx, 128);
    chk("stall_result", result, exp_sum(32'h4000, 128));

    // Error response on beat index 5: run completes, err set
    snap();
    err_beat = 5;
    pulse_start(32'h5000, 32);
    wait_done("resp", n);
    err_beat = 32'hFFFF_FFFF;
    chk("resp_err", 32'(err), 1);
    chk("resp_beats", beats_rx, 32);
    chk("resp_ars", ar_cnt - ar0, 2);
    chk("resp_result", result, exp_sum(32'h5000, 32));

    // New start clears done/err; unaligned base is truncated to burst alignment
    snap();
    pulse_start(32'h1003, 16);
    chk("restart_done", 32'(done), 0);
    chk("restart_err", 32'(err), 0);
    chk("restart_macstart", 32'(mac_start), 1);
    wait_done("align", n);
    chk("align_addr", ar_addr[ar0 % 256], 32'h1000);
    chk("align_ars", ar_cnt - ar0, 1);
    chk("align_result", result, exp_sum(32'h1000, 16));
    chk("align_err", 32'(err), 0);

    // Abort while an AR is waiting for arready: that AR still completes, nothing more
    snap();
    axi.m_axi_arready = 1'b0;
    pulse_start(32'h6000, 64);
    repeat (3) @(negedge clk);
    chk("abh_arvalid_pre", 32'(axi.m_axi_arvalid), 1);
    pulse_abort();
    repeat (2) @(negedge clk);
    chk("abh_arvalid_held", 32'(axi.m_axi_arvalid), 1);
    axi.m_axi_arready = 1'b1;
    wait_done("abh", n);
    chk("abh_ars", ar_cnt - ar0, 1);
    chk("abh_beats", beats_rx, 16);
    chk("abh_err", 32'(err), 1);
    chk("abh_result", result, exp_sum(32'h6000, 16));

    // Abort with MAX_OUTST bursts in flight: they drain fully
    snap();
    r_en = 1'b0;
    pulse_start(32'h7000, 256);
    repeat (20) @(negedge clk);
    pulse_abort();
    repeat (5) @(negedge clk);
    chk("abf_ars_mid", ar_cnt - ar0, 4);
    r_en = 1'b1;
    wait_done("abf", n);
    chk("abf_ars", ar_cnt - ar0, 4);
    chk("abf_beats", beats_rx, 64);
    chk("abf_err", 32'(err), 1);
    chk("abf_result", result, exp_sum(32'h7000, 64));

    // Reset mid-run returns to idle at once
    pulse_start(32'h8000, 64);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("rrst_busy", 32'(busy), 0);
    chk("rrst_arvalid", 32'(axi.m_axi_arvalid), 0);
    chk("rrst_beats", beats_rx, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
